servo_move_sequencer: RTL and testbench
=======================================

Name: servo_move_sequencer

Overview:
- Timed motion-command scheduler in front of the servo controller.
- Accepts queued commands of the form {direction, duration in ms} over a valid/ready handshake and buffers them in a small FIFO.
- Drives the servo controller's direction and load inputs for exactly the commanded time, then inserts a stop/settle gap.
- Lets game/CPU logic issue move sequences without cycle-counting.

Parameters:
- CYCLES_PER_MS, 50000, clk cycles per millisecond (50 MHz system clock); must be >=2.
- SETTLE_MS, 20, stop gap after each move in ms (one 20 ms servo PWM period); 0 allowed.
- FIFO_DEPTH, 4, command queue depth; power of 2, >=2.
- DUR_W, 12, width of the duration field in ms.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept a command.
- cmd_dir  in  3  000 stop, 001 fwd, 010 back, 011 left, 100 right.
- cmd_dur  in  DUR_W  move duration in ms.
- abort  in  1  flush the queue and stop immediately.
- servo_dir  out  3  to the servo controller's direction input.
- servo_load  out  1  to the servo controller's useServo input; a 1-cycle pulse latches servo_dir.
- busy  out  1  high when state != IDLE or the queue is non-empty.
- done  out  1  1-cycle pulse at the end of each command's settle gap.

Behaviour:
- **Clock and reset:** Single clock domain (clk). Reset is synchronous and active-low (rst_n).
- **Reset state (while rst_n=0):**
  - servo_dir=000 and servo_load=1, so downstream latches stop during reset.
  - cmd_ready=0, busy=0, done=0.
  - FIFO empty; state=IDLE; prescaler and ms counter cleared.
- **Handshake:**
  - A command is accepted at an edge where cmd_valid & cmd_ready.
  - cmd_ready = (count<FIFO_DEPTH) & ~abort & rst_n. It does not combinationally depend on a pop in the same cycle (no pass-through when full).
- **Direction mapping:** cmd_dir values 101..111 are stored unchanged, but the block drives servo_dir=000 for them. Their duration is still timed.
- **FSM states:** IDLE, RUN, SETTLE.
- **IDLE:**
  - If the FIFO is non-empty: pop the head.
  - If dur>0: load RUN. servo_dir=dir and servo_load=1, registered at the same edge (visible in the cycle after it). ms counter=dur, prescaler=0.
  - If dur=0: skip straight to SETTLE, driving servo_dir=000 with a load pulse.
  - Latency: a command accepted at edge E0 into an empty queue in IDLE produces a servo_load pulse in the cycle after E1.
- **RUN:**
  - Prescaler counts 0..CYCLES_PER_MS-1. At wrap, the ms counter decrements.
  - When the ms counter reaches 0: go to SETTLE with servo_dir=000 and servo_load=1.
  - Exact RUN length = dur*CYCLES_PER_MS cycles, measured from the load pulse to the stop pulse.
  - servo_load is 0 in all other RUN cycles.
- **SETTLE:**
  - Counts SETTLE_MS*CYCLES_PER_MS cycles (1 cycle if SETTLE_MS=0).
  - At the end, pulse done=1 for one cycle.
  - If the FIFO is non-empty at that edge, pop the next command and enter RUN in the same edge (back-to-back, no idle cycle). Otherwise go to IDLE.
- **Abort (highest priority; acts at any edge with abort=1 and rst_n=1):**
  - FIFO flushed, counters cleared, state=IDLE.
  - servo_dir=000, servo_load=1 for one cycle; done=0.
  - A cmd_valid in the same cycle is dropped (cmd_ready=0).
- **Simultaneous push and pop** (FIFO not full): both occur and the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- **Counter sizing:** all counters unsigned and sized by $clog2 of their maximum value; no overflow at dur = 2^DUR_W-1.

Decomposition:
- Shared package: direction encodings (DIR_STOP..DIR_RIGHT), FSM state enum, command struct {dir[2:0], dur[DUR_W-1:0]}.
- One sub-module: cmd_fifo (synchronous FIFO with push, pop, flush, count, full, empty), parameterised by depth and width.

Test Plan (CYCLES_PER_MS=10, SETTLE_MS=2, FIFO_DEPTH=4):
- **Single move:** reset, then push {001,3}.
  - servo_load with dir 001 in the cycle after E1.
  - Stop pulse (000) exactly 30 cycles later.
  - done pulse 20 cycles after that; busy then drops.
- **Back-to-back:** push {011,1},{100,2} consecutively.
  - Second dir load pulse in the same cycle as the first done.
  - Dir 100 held for 20 cycles.
- **Full queue:** during a long move, push 5 commands.
  - cmd_ready=0 after the 4th is accepted; the 5th waits.
  - Accepted once the next command is popped; all 5 execute in order.
- **Abort mid-RUN with 2 queued:**
  - Next cycle: servo_dir=000 with a load pulse.
  - FIFO empty, busy=0, no done.
  - cmd_valid in the abort cycle is ignored.
- **Edge commands:**
  - {010,0}: no RUN, stop pulse, done after 20 cycles.
  - {110,1}: servo_dir stays 000 for 10 cycles, then settle.
- **Reset mid-SETTLE:**
  - While rst_n=0: servo_load=1, servo_dir=000, cmd_ready=0.
  - After release: IDLE, queue empty, no spurious done.

Source files
------------

// File: rtl/servo_move_sequencer_pkg.sv
// Shared types for the servo move sequencer: direction codes, FSM states and
// the queued command layout.
package servo_move_sequencer_pkg;

  localparam int unsigned CMD_DUR_W = 12;

  localparam logic [2:0] DIR_STOP  = 3'b000;
  localparam logic [2:0] DIR_FWD   = 3'b001;
  localparam logic [2:0] DIR_BACK  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE
  } state_t;

  typedef struct packed {
    logic [2:0]           dir;
    logic [CMD_DUR_W-1:0] dur;
  } cmd_t;

  // Codes above DIR_RIGHT are kept in the queue but never reach the servo.
  function automatic logic [2:0] servo_dir_of(input logic [2:0] dir);
    return (dir > DIR_RIGHT) ? DIR_STOP : dir;
  endfunction

endpackage

// File: rtl/servo_move_sequencer_cmd_fifo.sv
// Synchronous command FIFO with flush; pointers wrap naturally because the
// depth is a power of two.
module servo_move_sequencer_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/servo_move_sequencer.sv
// Timed motion-command scheduler: queues {dir, dur_ms} commands and drives the
// servo controller for exactly the commanded time, followed by a settle gap.
module servo_move_sequencer
  import servo_move_sequencer_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = 50000,
  parameter int unsigned SETTLE_MS     = 20,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DUR_W         = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_dir,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic [2:0]       servo_dir,
  output logic             servo_load,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CMD_W      = 3 + DUR_W;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PRE_W      = $clog2(CYCLES_PER_MS);
  localparam int unsigned SETTLE_RAW = SETTLE_MS * CYCLES_PER_MS;
  localparam int unsigned SETTLE_CYC = (SETTLE_RAW == 0) ? 1 : SETTLE_RAW;
  localparam int unsigned SET_W      = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_MS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_t             state;
  logic [PRE_W-1:0]   presc;
  logic [DUR_W-1:0]   ms_left;
  logic [SET_W-1:0]   settle_cnt;

  logic               push;
  logic               pop;
  logic [CMD_W-1:0]   head;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [2:0]         head_dir;
  logic [DUR_W-1:0]   head_dur;
  logic               settle_end;

  assign cmd_ready  = ~full & ~abort & rst_n;
  assign push       = cmd_valid & cmd_ready;
  assign busy       = (state != ST_IDLE) | (count != '0);
  assign head_dir   = head[CMD_W-1 -: 3];
  assign head_dur   = head[DUR_W-1:0];
  assign settle_end = (state == ST_SETTLE) && (settle_cnt == SET_LAST);
  // Next command leaves the queue from IDLE or at the last settle cycle.
  assign pop        = ~empty & ((state == ST_IDLE) | settle_end);

  servo_move_sequencer_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata ({cmd_dir, cmd_dur}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state      <= ST_IDLE;
      presc      <= '0;
      ms_left    <= '0;
      settle_cnt <= '0;
      servo_dir  <= DIR_STOP;
      servo_load <= 1'b1;
      done       <= 1'b0;
    end else begin
      servo_load <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: ;
        ST_RUN: begin
          if (presc == PRE_LAST) begin
            presc   <= '0;
            ms_left <= ms_left - DUR_W'(1);
            if (ms_left == DUR_W'(1)) begin
              state      <= ST_SETTLE;
              settle_cnt <= '0;
              servo_dir  <= DIR_STOP;
              servo_load <= 1'b1;
            end
          end else begin
            presc <= presc + PRE_W'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            done       <= 1'b1;
            settle_cnt <= '0;
            state      <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Dispatch overrides the case above; zero-length moves go straight to settle.
      if (pop) begin
        servo_load <= 1'b1;
        presc      <= '0;
        settle_cnt <= '0;
        ms_left    <= head_dur;
        if (head_dur != '0) begin
          state     <= ST_RUN;
          servo_dir <= servo_dir_of(head_dir);
        end else begin
          state     <= ST_SETTLE;
          servo_dir <= DIR_STOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Randomised and directed bench for servo_move_sequencer, checked every cycle
// against a queue-and-countdown model of the command schedule.
module tb_servo_move_sequencer;
  import servo_move_sequencer_pkg::*;

  localparam int CPM        = 10;
  localparam int SMS        = 2;
  localparam int DEPTH      = 4;
  localparam int DW         = 12;
  localparam int SETTLE_CYC = SMS * CPM;

  localparam int PH_IDLE = 0;
  localparam int PH_MOVE = 1;
  localparam int PH_GAP  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_dir;
  logic [DW-1:0] cmd_dur;
  logic          abort;
  logic [2:0]    servo_dir;
  logic          servo_load;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  cmd_t       m_q[$];
  int         m_phase;
  int         m_left;
  logic [2:0] m_dir;
  logic       m_load;
  logic       m_done;
  logic       m_accepted;

  always #5 clk = ~clk;

  servo_move_sequencer #(
    .CYCLES_PER_MS (CPM),
    .SETTLE_MS     (SMS),
    .FIFO_DEPTH    (DEPTH),
    .DUR_W         (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_dur    (cmd_dur),
    .abort      (abort),
    .servo_dir  (servo_dir),
    .servo_load (servo_load),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // A move lasts dur ms of cycles; a zero-length move is only a settle gap.
  task automatic model_start(input cmd_t c);
    m_load = 1'b1;
    if (c.dur == 0) begin
      m_phase = PH_GAP;
      m_left  = SETTLE_CYC;
      m_dir   = 3'b000;
    end else begin
      m_phase = PH_MOVE;
      m_left  = int'(c.dur) * CPM;
      m_dir   = (c.dir <= 3'd4) ? c.dir : 3'b000;
    end
  endtask

  task automatic model_edge();
    cmd_t nc;
    bit   can_push;
    m_accepted = 1'b0;
    if (!rst_n || abort) begin
      m_q.delete();
      m_phase = PH_IDLE;
      m_left  = 0;
      m_dir   = 3'b000;
      m_load  = 1'b1;
      m_done  = 1'b0;
    end else begin
      can_push = cmd_valid && (m_q.size() < DEPTH);
      nc.dir   = cmd_dir;
      nc.dur   = cmd_dur;
      m_load   = 1'b0;
      m_done   = 1'b0;
      case (m_phase)
        PH_IDLE: if (m_q.size() > 0) model_start(m_q.pop_front());
        PH_MOVE: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = PH_GAP;
            m_left  = SETTLE_CYC;
            m_dir   = 3'b000;
            m_load  = 1'b1;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            if (m_q.size() > 0) model_start(m_q.pop_front());
            else m_phase = PH_IDLE;
          end
        end
      endcase
      if (can_push) begin
        m_q.push_back(nc);
        m_accepted = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("servo_dir",  32'(servo_dir),  32'(m_dir));
    check("servo_load", 32'(servo_load), 32'(m_load));
    check("done",       32'(done),       32'(m_done));
    check("busy",       32'(busy),       32'(m_phase != PH_IDLE || m_q.size() != 0));
    check("cmd_ready",  32'(cmd_ready),  32'(m_q.size() < DEPTH && !abort && rst_n));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_cmd(input logic [2:0] d, input int dur);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_dur   = DW'(dur);
    for (int i = 0; i < 500 && !ok; i++) begin
      cycle();
      ok = m_accepted;
    end
    cmd_valid = 1'b0;
    if (!ok) check("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_phase != PH_IDLE || m_q.size() != 0) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) check("idle_timeout", 32'(0), 32'(1));
    idle_cycles(3);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 3'b000;
    cmd_dur   = '0;
    abort     = 1'b0;
    m_phase   = PH_IDLE;
    m_left    = 0;
    m_dir     = 3'b000;
    m_load    = 1'b1;
    m_done    = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single move, then back-to-back pair.
    push_cmd(DIR_FWD, 3);
    wait_idle();
    push_cmd(DIR_LEFT, 1);
    push_cmd(DIR_RIGHT, 2);
    wait_idle();

    // Fill the queue behind a long move; the fifth push has to wait.
    push_cmd(DIR_FWD, 8);
    push_cmd(DIR_BACK, 1);
    push_cmd(DIR_LEFT, 2);
    push_cmd(DIR_RIGHT, 1);
    push_cmd(DIR_FWD, 1);
    push_cmd(DIR_BACK, 2);
    wait_idle();

    // Abort mid-move with commands queued and a push in the same cycle.
    push_cmd(DIR_FWD, 5);
    push_cmd(DIR_BACK, 1);
    push_cmd(DIR_LEFT, 1);
    idle_cycles(10);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = DIR_RIGHT;
    cmd_dur   = DW'(1);
    cycle();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    idle_cycles(5);

    // Zero-length move and an unmapped direction.
    push_cmd(DIR_BACK, 0);
    wait_idle();
    push_cmd(3'b110, 1);
    wait_idle();

    // Reset during the settle gap.
    push_cmd(DIR_FWD, 1);
    idle_cycles(15);
    rst_n = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(30);

    // Random traffic with occasional abort and reset.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom % 10) < 4;
      cmd_dir   = 3'($urandom);
      cmd_dur   = DW'($urandom_range(0, 3));
      abort     = ($urandom % 150) == 0;
      rst_n     = ($urandom % 400) != 0;
      cycle();
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    rst_n     = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
